password_ctrl: RTL and testbench

- Sequencing FSM for the 4-digit password lock; sits between switch/button inputs and the LED/7-segment display decoder.
- Drives the 4-bit `state` code the decoder consumes: 0 idle, 1–3 digit progress, 4 done, 5 error, 6 lockout (decoder shows blank).
- Collects 4 entered digits and compares them against a parameterised code.
- Enforces an inactivity timeout, a display hold time and a failure lockout.

---
 rtl/password_ctrl.sv | 175 +++++++++++++++++
 tb/tb_password_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/password_ctrl.sv
// Four-digit password lock sequencer: synchronizes the enter/clear buttons and walks IDLE -> D2..D4 -> DONE/ERROR.
// The failure lockout (LOCK state, MAX_TRIES, LOCK_CYC) exists only when PWD_LOCKOUT_EN is defined.
module password_ctrl #(
    parameter logic [15:0] CODE        = 16'h1234,
    parameter int          MAX_TRIES   = 3,
    parameter int          TIMEOUT_CYC = 50000000,
    parameter int          HOLD_CYC    = 100000000,
    parameter int          LOCK_CYC    = 500000000,
    parameter int          TMR_W       = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       enter,
    input  logic       clear,
    output logic [3:0] state,
    output logic       unlock,
    output logic       locked,
    output logic [2:0] fail_cnt
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_D2    = 4'd1;
    localparam logic [3:0] S_D3    = 4'd2;
    localparam logic [3:0] S_D4    = 4'd3;
    localparam logic [3:0] S_DONE  = 4'd4;
    localparam logic [3:0] S_ERROR = 4'd5;
    localparam logic [3:0] S_LOCK  = 4'd6;

`ifdef PWD_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic [2:0]       ent_sync_q, ent_sync_d;
    logic [2:0]       clr_sync_q, clr_sync_d;
    logic [3:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             mis_q, mis_d;
    logic [2:0]       fail_q, fail_d;
    logic             unlock_q, unlock_d;
    logic             locked_q, locked_d;

    logic       ent_ev, clr_ev;
    logic [3:0] code_nib;
    logic       mis_next;
    logic [2:0] fail_sat;

    // Bit 0/1 are the synchronizer pair, bit 2 is the edge-detect delay.
    assign ent_sync_d = {ent_sync_q[1:0], enter};
    assign clr_sync_d = {clr_sync_q[1:0], clear};
    assign ent_ev     = ent_sync_q[1] & ~ent_sync_q[2];
    assign clr_ev     = clr_sync_q[1] & ~clr_sync_q[2];
    assign fail_sat   = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_sync_q <= '0;
            clr_sync_q <= '0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            mis_q      <= 1'b0;
            fail_q     <= '0;
            unlock_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            ent_sync_q <= ent_sync_d;
            clr_sync_q <= clr_sync_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            mis_q      <= mis_d;
            fail_q     <= fail_d;
            unlock_q   <= unlock_d;
            locked_q   <= locked_d;
        end
    end

    always_comb begin
        code_nib = CODE[3:0];
        case (state_q)
            S_D2:    code_nib = CODE[11:8];
            S_D3:    code_nib = CODE[7:4];
            default: code_nib = CODE[3:0];
        endcase
        mis_next = mis_q | (digit_in != code_nib);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mis_d   = mis_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (ent_ev) begin
                    mis_d   = (digit_in != CODE[15:12]);
                    state_d = S_D2;
                    timer_d = '0;
                end
            end
            S_D2, S_D3, S_D4: begin
                // Abort beats timeout, timeout beats a digit entry.
                if (clr_ev) begin
                    state_d = S_IDLE;
                    mis_d   = 1'b0;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d = S_ERROR;
                    fail_d  = fail_sat;
                    timer_d = '0;
                end else if (ent_ev) begin
                    mis_d   = mis_next;
                    timer_d = '0;
                    if (state_q == S_D2) begin
                        state_d = S_D3;
                    end else if (state_q == S_D3) begin
                        state_d = S_D4;
                    end else if (mis_next) begin
                        state_d = S_ERROR;
                        fail_d  = fail_sat;
                    end else begin
                        state_d = S_DONE;
                        fail_d  = '0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                if (clr_ev) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            S_ERROR: begin
                if (timer_q == TMR_W'(HOLD_CYC - 1)) begin
                    timer_d = '0;
                    state_d = (LOCK_EN && int'(fail_q) >= MAX_TRIES) ? S_LOCK : S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_LOCK: begin
                if (!LOCK_EN) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(LOCK_CYC - 1)) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                mis_d   = 1'b0;
            end
        endcase
    end

    // Status flags follow the next state so they flip on the same edge as state.
    always_comb begin
        unlock_d = (state_d == S_DONE);
        locked_d = LOCK_EN && (state_d == S_LOCK);
    end

    assign state    = state_q;
    assign unlock   = unlock_q;
    assign locked   = locked_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_password_ctrl.sv
// Directed bench for password_ctrl with short timers (TIMEOUT 20, HOLD 8, LOCK 16).
// Lockout expectations follow PWD_LOCKOUT_EN as seen by this file.
module tb_password_ctrl;

`ifdef PWD_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] digit_in;
    logic       enter;
    logic       clear;
    logic [3:0] state;
    logic       unlock;
    logic       locked;
    logic [2:0] fail_cnt;

    int total = 0;
    int bad   = 0;

    password_ctrl #(
        .CODE(16'h1234), .MAX_TRIES(3), .TIMEOUT_CYC(20),
        .HOLD_CYC(8), .LOCK_CYC(16), .TMR_W(29)
    ) dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .enter(enter), .clear(clear),
        .state(state), .unlock(unlock), .locked(locked), .fail_cnt(fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Raise enter with digit d; state must hold for 2 edges and change on the 3rd.
    task automatic press(input logic [3:0] d, input int st_before, input int st_after);
        @(posedge clk); #1;
        digit_in = d;
        enter = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("press_hold", state, st_before);
        @(posedge clk);
        #1 chk("press_step", state, st_after);
        repeat (2) @(posedge clk);
        #1 enter = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic clr_pulse(input int st_before, input int st_after);
        @(posedge clk); #1;
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("clr_hold", state, st_before);
        @(posedge clk);
        #1 chk("clr_step", state, st_after);
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic correct_entry();
        press(4'd1, 0, 1);
        press(4'd2, 1, 2);
        press(4'd3, 2, 3);
        press(4'd4, 3, 4);
        chk("done_unlock", unlock, 1);
        chk("done_fail", fail_cnt, 0);
        chk("done_locked", locked, 0);
    endtask

    // Wrong code 5555; ERROR is entered at edge X, checked at X+7 and X+8.
    task automatic wrong_entry(input int fail_exp, input int st_after_hold);
        press(4'd5, 0, 1);
        press(4'd5, 1, 2);
        press(4'd5, 2, 3);
        press(4'd5, 3, 5);
        chk("wrong_fail", fail_cnt, fail_exp);
        repeat (2) @(posedge clk);
        #1 chk("wrong_hold", state, 5);
        @(posedge clk);
        #1 chk("wrong_exit", state, st_after_hold);
        chk("wrong_locked", locked, (st_after_hold == 6) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        digit_in = 4'd0;
        enter = 1'b0;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_unlock", unlock, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fail", fail_cnt, 0);
        rst = 1'b1;

        // Correct code, then clear relocks
        correct_entry();
        clr_pulse(4, 0);
        chk("clr_unlock", unlock, 0);

        // Wrong middle digit: all four digits collected, then ERROR for 8 cycles
        press(4'd1, 0, 1);
        press(4'd9, 1, 2);
        press(4'd3, 2, 3);
        press(4'd4, 3, 5);
        chk("mid_fail", fail_cnt, 1);
        chk("mid_unlock", unlock, 0);
        repeat (2) @(posedge clk);
        #1 chk("mid_hold", state, 5);
        @(posedge clk);
        #1 chk("mid_exit", state, 0);

        // Inactivity timeout: D2 entered at Y, ERROR at Y+20, IDLE at Y+28
        press(4'd1, 0, 1);
        repeat (14) @(posedge clk);
        #1 chk("to_before", state, 1);
        @(posedge clk);
        #1 chk("to_state", state, 5);
        chk("to_fail", fail_cnt, 2);
        repeat (7) @(posedge clk);
        #1 chk("to_hold", state, 5);
        @(posedge clk);
        #1 chk("to_exit", state, 0);

        // Abort: clear and enter rise together while in D3
        press(4'd1, 0, 1);
        press(4'd2, 1, 2);
        @(posedge clk); #1;
        digit_in = 4'd3;
        enter = 1'b1;
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("abort_hold", state, 2);
        @(posedge clk);
        #1 chk("abort_state", state, 0);
        chk("abort_fail", fail_cnt, 2);
        repeat (2) @(posedge clk);
        #1 enter = 1'b0;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("abort_stay", state, 0);

        // Success clears the failure count
        correct_entry();
        clr_pulse(4, 0);

        // Three consecutive failures
        for (int i = 0; i < 3; i++) begin
            wrong_entry(i + 1, (i == 2 && LOCK_EN) ? 6 : 0);
        end

`ifdef PWD_LOCKOUT_EN
        // LOCK entered at L; an enter press is ignored; exit at L+16
        press(4'd1, 6, 6);
        repeat (6) @(posedge clk);
        #1 chk("lock_hold", state, 6);
        chk("lock_flag", locked, 1);
        @(posedge clk);
        #1 chk("lock_exit", state, 0);
        chk("lock_exit_flag", locked, 0);
        chk("lock_exit_fail", fail_cnt, 0);

        for (int i = 0; i < 3; i++) begin
            wrong_entry(i + 1, (i == 2) ? 6 : 0);
        end
        repeat (5) @(posedge clk);
`else
        chk("nolock_fail", fail_cnt, 3);
        press(4'd1, 0, 1);
`endif
        // Synchronous reset mid-state
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        chk("mrst_state", state, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_fail", fail_cnt, 0);
        repeat (3) @(posedge clk);
        #1 chk("mrst_stay", state, 0);
        correct_entry();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
